demux_1t8_32: RTL

DEMUX_1T8_32 -- requirements
Module: demux_1t8_32

---
 rtl/demux_1t8_32.sv | 87 ++++++++
 1 files changed

// File: rtl/demux_1t8_32.sv
// 1-to-8 demultiplexer, 32-bit words, valid/ready on every side.
// Optional per-word timeout drops a stalled word and counts it.
module demux_1t8_32 #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sel,
  input  logic [31:0] in_data,
  output logic [7:0]  out_valid,
  output logic [31:0] out_data,
  input  logic [7:0]  out_ready,
  output logic        err,
  output logic [7:0]  drop_cnt
);

  localparam bit        LP_TMO_EN = (TIMEOUT != 0);
  localparam logic [7:0] LP_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t      r_state;
  logic [2:0]  r_sel;
  logic [7:0]  r_wait;
  logic [7:0]  r_valid;
  logic [31:0] r_data;
  logic        r_err;
  logic [7:0]  r_drops;

  logic w_rdy;
  logic w_tmo;

  assign w_rdy = out_ready[r_sel];
  assign w_tmo = LP_TMO_EN && !w_rdy && (r_wait == LP_LAST);

  // in_ready is a pure decode of the registered state
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign err       = r_err;
  assign drop_cnt  = r_drops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'd0;
      r_wait  <= 8'd0;
      r_valid <= 8'h00;
      r_data  <= 32'h0;
      r_err   <= 1'b0;
      r_drops <= 8'd0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= ST_SEND;
            r_sel   <= in_sel;
            r_data  <= in_data;
            r_wait  <= 8'd0;
            r_valid <= 8'h01 << in_sel;
          end
        end
        ST_SEND: begin
          if (w_rdy) begin
            r_state <= ST_IDLE;
            r_valid <= 8'h00;
          end else if (w_tmo) begin
            r_state <= ST_IDLE;
            r_valid <= 8'h00;
            r_err   <= 1'b1;
            if (r_drops != 8'hFF)
              r_drops <= r_drops + 8'd1;
          end else if (LP_TMO_EN) begin
            r_wait <= r_wait + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
